// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: shifts a WIDTH-bit payload out MSB-first, then a 2-bit
// check field that makes the whole frame, read as an unsigned number, divisible by 3.
module mod3_frame_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             tx_en_i,
    output logic             tx_o,
    output logic             tx_valid_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a word transfers on a rising edge where valid_i && ready_o; ready_o
    // is high only in IDLE, and the upstream holds data_i/valid_i until that edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [1:0]       r_res;
    logic [CW-1:0]    r_cnt;

    logic [1:0]       w_res_next;
    logic [1:0]       w_chk;
    logic             w_bit;

    // Residue update (2*r + b) mod 3; r never holds 3.
    always_comb begin
        w_res_next = 2'd0;
        case ({r_res, r_shift[WIDTH-1]})
            3'b000:  w_res_next = 2'd0;
            3'b001:  w_res_next = 2'd1;
            3'b010:  w_res_next = 2'd2;
            3'b011:  w_res_next = 2'd0;
            3'b100:  w_res_next = 2'd1;
            3'b101:  w_res_next = 2'd2;
            default: w_res_next = 2'd0;
        endcase
    end

    always_comb begin
        w_chk = 2'b00;
        case (r_res)
            2'd1:    w_chk = 2'b10;
            2'd2:    w_chk = 2'b01;
            default: w_chk = 2'b00;
        endcase
    end

    // In CHECK the counter runs 1 then 0, selecting c[1] then c[0].
    assign w_bit = (r_state == S_DATA) ? r_shift[WIDTH-1]
                                       : (r_cnt[0] ? w_chk[1] : w_chk[0]);

    assign ready_o     = (r_state == S_IDLE);
    assign tx_valid_o  = (r_state != S_IDLE) && tx_en_i;
    assign tx_o        = tx_valid_o && w_bit;
    assign sof_o       = tx_valid_o && (r_state == S_DATA) && (r_cnt == CNT_MAX);
    assign eof_o       = tx_valid_o && (r_state == S_CHECK) && (r_cnt == CNT_ZERO);
    assign dbg_state_o = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_res   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_shift <= data_i;
                        r_res   <= 2'd0;
                        r_cnt   <= CNT_MAX;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_en_i) begin
                        r_res   <= w_res_next;
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        if (r_cnt == CNT_ZERO) begin
                            r_cnt   <= CNT_ONE;
                            r_state <= S_CHECK;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                S_CHECK: begin
                    if (tx_en_i) begin
                        if (r_cnt == CNT_ZERO) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx (WIDTH=8): scoreboard of expected frame bits and frame
// values, with a divisible-by-3 checker model fed from the serial output.
module tb_mod3_frame_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_en_i;
  logic       tx_o;
  logic       tx_valid_o;
  logic       sof_o;
  logic       eof_o;
  logic [1:0] dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int sof_cnt = 0;
  int eof_cnt = 0;

  logic [2:0] exp_q[$];
  logic [9:0] frame_q[$];
  logic [9:0] fv;
  logic [9:0] last_frame;
  int         chk_res;

  mod3_frame_tx #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .tx_en_i     (tx_en_i),
    .tx_o        (tx_o),
    .tx_valid_o  (tx_valid_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] v);
    int r;
    int c;
    logic [9:0] f;
    r = int'(v) % 3;
    c = (3 - r) % 3;
    f = {v, c[1:0]};
    for (int i = 9; i >= 0; i--) exp_q.push_back({f[i], i == 9, i == 0});
    frame_q.push_back(f);
  endtask

  // driver: call at any time; aligns to posedge+1 before presenting the word
  task automatic send_frame(input logic [7:0] v);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    data_i  = v;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("accept_timeout", 0, 1);
      valid_i = 1'b0;
    end else begin
      push_frame(v);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || !ready_o) && n < 300);
    if (exp_q.size() != 0 || !ready_o) check("idle_timeout", 0, 1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [2:0] e;
    if (!reset) begin
      if (!tx_valid_o) check("tx_o_when_invalid", tx_o, 0);
      if (!tx_en_i) check("txv_when_disabled", tx_valid_o, 0);
      if (tx_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("bit", tx_o, e[2]);
          check("sof", sof_o, e[1]);
          check("eof", eof_o, e[0]);
        end
        if (sof_o) begin
          fv = '0;
          chk_res = 0;
          sof_cnt++;
        end
        fv = {fv[8:0], tx_o};
        chk_res = (2 * chk_res + int'(tx_o)) % 3;
        if (eof_o) begin
          eof_cnt++;
          last_frame = fv;
          check("div3_checker", chk_res == 0, 1);
          check("frame_mod3", fv % 3, 0);
          if (frame_q.size() == 0) check("unexpected_frame", 1, 0);
          else check("frame_value", fv, frame_q.pop_front());
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [9:0]  ref05;
    logic [7:0]  enc_v[4];
    logic [9:0]  enc_f[4];
    logic [3:0]  pat;
    int          s0;
    int          e0;
    int          i;
    bit          acc;

    ref05 = 10'b0000010101;
    enc_v = '{8'h03, 8'h01, 8'hFF, 8'h00};
    enc_f = '{10'd12, 10'd6, 10'd1020, 10'd0};
    pat   = 4'b1001;

    reset   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    tx_en_i = 1'b1;
    fv      = '0;
    chk_res = 0;
    last_frame = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_tx_o", tx_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_sof", sof_o, 0);
    check("rst_eof", eof_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 0x05 with exact cycle timing
    send_frame(8'h05);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 10) check("t05_bit", tx_o, ref05[10-k]);
      check("t05_sof", sof_o, k == 1);
      check("t05_eof", eof_o, k == 10);
      check("t05_ready", ready_o, k == 11);
    end
    wait_idle();
    check("t05_frame", last_frame, 21);

    // check-field encodings
    for (int k = 0; k < 4; k++) begin
      s0 = sof_cnt;
      e0 = eof_cnt;
      send_frame(enc_v[k]);
      wait_idle();
      check("enc_frame", last_frame, enc_f[k]);
      check("enc_sof_count", sof_cnt - s0, 1);
      check("enc_eof_count", eof_cnt - e0, 1);
    end

    // exhaustive payloads
    e0 = eof_cnt;
    for (int v = 0; v < 256; v++) begin
      send_frame(v[7:0]);
      wait_idle();
    end
    check("exh_eof_count", eof_cnt - e0, 256);

    // tx_en_i gating pattern 1,0,0,1
    send_frame(8'hA6);
    i = 1;
    while (exp_q.size() != 0 && i < 100) begin
      @(posedge clk);
      #1;
      tx_en_i = pat[3 - (i % 4)];
      i++;
    end
    tx_en_i = 1'b1;
    wait_idle();
    check("pat_frame", last_frame, 666);

    // valid_i held high with data_i changing mid-frame
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    data_i  = 8'h5A;
    @(negedge clk);
    check("hold_ready0", ready_o, 1);
    push_frame(8'h5A);
    acc = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      data_i = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (ready_o) begin
        check("hold_gap", k, 11);
        push_frame(data_i);
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("hold_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_idle();

    // reset on bit 4 of a frame
    send_frame(8'h35);
    repeat (3) @(posedge clk);
    #1;
    e0 = eof_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_tx_o", tx_o, 0);
    check("mid_rst_tx_valid", tx_valid_o, 0);
    check("mid_rst_sof", sof_o, 0);
    check("mid_rst_eof", eof_o, 0);
    check("mid_rst_state", dbg_state_o, 0);
    exp_q.delete();
    frame_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ready", ready_o, 1);
    check("post_rst_no_eof", eof_cnt - e0, 0);
    send_frame(8'h05);
    wait_idle();
    check("post_rst_frame", last_frame, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
